// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Digit type, state encoding and a digit range helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'h9;

  function automatic logic digit_ok(
    input bcd_digit_t d
  );
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_dec.sv
// Combinational packed-BCD decrement with all-zero flag.
// An all-zero input yields all nines; the caller must guard it.
module bcd_dec
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] i_count,
  output logic [4*DIGITS-1:0] o_dec,
  output logic                o_zero
);

  logic       w_borrow;
  bcd_digit_t w_d;

  // Ripple the borrow from digit 0 upward.
  always_comb begin
    w_borrow = 1'b1;
    w_d      = '0;
    o_dec    = i_count;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = i_count[4*i +: 4];
      if (w_borrow) begin
        if (w_d == 4'h0) begin
          o_dec[4*i +: 4] = BCD_NINE;
        end else begin
          o_dec[4*i +: 4] = w_d - 4'h1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  assign o_zero = (i_count == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Loadable BCD countdown timer with run/pause control.
// Define BCD_COUNTDOWN_RELOAD_EN for periodic reload mode.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_load_err;
  logic           w_err_nxt;
  logic [W-1:0]   w_dec;
  logic           w_zero;
  logic           w_is_one;
  logic           w_load_ok;
  logic           w_load_win;
`ifdef BCD_COUNTDOWN_RELOAD_EN
  logic [W-1:0]   r_reload;
  logic [W-1:0]   w_reload_nxt;
`endif

  bcd_dec #(
    .DIGITS (DIGITS)
  ) u_dec (
    .i_count (r_count),
    .o_dec   (w_dec),
    .o_zero  (w_zero)
  );

  assign w_is_one   = (r_count == CNT_ONE);
  assign w_load_win = (r_state == S_IDLE) ||
                      (r_state == S_DONE);

  // Every digit of the requested load must be 0..9.
  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(load_val[4*i +: 4])) begin
        w_load_ok = 1'b0;
      end
    end
  end

  // Next-state, next-count and pulse generation.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
`ifdef BCD_COUNTDOWN_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    if (load && w_load_win) begin
      if (w_load_ok) begin
        w_count_nxt  = load_val;
        w_state_nxt  = S_IDLE;
`ifdef BCD_COUNTDOWN_RELOAD_EN
        w_reload_nxt = load_val;
`endif
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            w_state_nxt = S_PAUSED;
          end else if (tick) begin
            if (w_zero) begin
              w_state_nxt = S_DONE;
            end else if (w_is_one) begin
              w_done_nxt  = 1'b1;
`ifdef BCD_COUNTDOWN_RELOAD_EN
              w_count_nxt = r_reload;
`else
              w_count_nxt = '0;
              w_state_nxt = S_DONE;
`endif
            end else begin
              w_count_nxt = w_dec;
            end
          end
        end
        S_PAUSED: begin
          if (start && !pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_count_nxt = r_count;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, count and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_err_nxt;
    end
  end

`ifdef BCD_COUNTDOWN_RELOAD_EN
  // Reload value captured on every accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload <= '0;
    end else begin
      r_reload <= w_reload_nxt;
    end
  end
`endif

  assign count    = r_count;
  assign running  = (r_state == S_RUN);
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown.
// Covers the default build and BCD_COUNTDOWN_RELOAD_EN.
module tb_bcd_countdown;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [11:0] load_val;
  logic        start;
  logic        pause;
  logic        tick;
  logic [11:0] count;
  logic        running;
  logic        done;
  logic        load_err;

  int n_chk;
  int n_err;

  logic [11:0] exp_seq [6];

  bcd_countdown #(
    .DIGITS (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .count    (count),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    pause    = 1'b0;
    tick     = 1'b0;
    exp_seq  = '{12'h104, 12'h103, 12'h102,
                 12'h101, 12'h100, 12'h099};

    #12;
    chk("rst_count", count, 0);
    chk("rst_run", running, 0);
    chk("rst_done", done, 0);
    chk("rst_err", load_err, 0);
    rst_n = 1'b1;
    cyc();

    // Plain countdown with borrow.
    do_load(12'h105);
    chk("ld105", count, 12'h105);
    chk("ld105_run", running, 0);
    pulse_start();
    chk("st105_run", running, 1);
    for (int i = 0; i < 6; i++) begin
      pulse_tick();
      chk("dec_cnt", count, exp_seq[i]);
      chk("dec_run", running, 1);
    end
    do_reset();

    // Pause priority and resume.
    do_load(12'h050);
    pulse_start();
    tick  = 1'b1;
    pause = 1'b1;
    cyc();
    tick  = 1'b0;
    pause = 1'b0;
    chk("pz_cnt", count, 12'h050);
    chk("pz_run", running, 0);
    pulse_tick();
    chk("pz_tick", count, 12'h050);
    do_load(12'h777);
    chk("pz_ld_cnt", count, 12'h050);
    chk("pz_ld_err", load_err, 0);
    start = 1'b1;
    pause = 1'b1;
    cyc();
    start = 1'b0;
    pause = 1'b0;
    chk("pz_sp_run", running, 0);
    pulse_start();
    chk("pz_res_run", running, 1);
    pulse_tick();
    chk("pz_049", count, 12'h049);
    do_reset();

`ifdef BCD_COUNTDOWN_RELOAD_EN
    // Periodic reload.
    do_load(12'h002);
    pulse_start();
    pulse_tick();
    chk("rl_001", count, 12'h001);
    chk("rl_nodone", done, 0);
    pulse_tick();
    chk("rl_done", done, 1);
    chk("rl_cnt", count, 12'h002);
    chk("rl_run", running, 1);
    cyc();
    chk("rl_done_off", done, 0);
    pulse_tick();
    chk("rl_again", count, 12'h001);
    do_reset();
`else
    // Terminal count.
    do_load(12'h001);
    pulse_start();
    pulse_tick();
    chk("tc_cnt", count, 0);
    chk("tc_done", done, 1);
    chk("tc_run", running, 0);
    cyc();
    chk("tc_done_off", done, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      chk("tc_hold", count, 0);
      chk("tc_hold_dn", done, 0);
    end
`endif

    // Load acceptance and rejection.
    do_load(12'h010);
    chk("ld010", count, 12'h010);
    chk("ld010_run", running, 0);
    do_load(12'h1A3);
    chk("bad_err", load_err, 1);
    chk("bad_cnt", count, 12'h010);
    cyc();
    chk("bad_err_off", load_err, 0);

    // Start with zero count.
    do_load(12'h000);
    pulse_start();
    chk("z_done", done, 1);
    chk("z_run", running, 0);
    chk("z_cnt", count, 0);

    // Load and start together.
    do_load(12'h005);
    load     = 1'b1;
    load_val = 12'h321;
    start    = 1'b1;
    cyc();
    load  = 1'b0;
    start = 1'b0;
    chk("ls_cnt", count, 12'h321);
    chk("ls_run", running, 0);

    // Reset abandons a running count.
    pulse_start();
    chk("mr_run", running, 1);
    chk("mr_cnt", count, 12'h321);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_cnt", count, 0);
    chk("mr_rst_run", running, 0);
    #2;
    rst_n = 1'b1;
    tick  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mr_no_done", done, 0);
      chk("mr_cnt0", count, 0);
    end
    tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
